// File: rtl/sprite_draw_arbiter_pkg.sv
// Shared types and constants for the sprite draw arbiter: FSM encoding,
// requester count, timeout default and per-GU frame-buffer field widths.
package sprite_draw_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int NUM_GU          = 4;
    localparam int TIMEOUT_DEFAULT = 4096;
    localparam int X_W             = 9;
    localparam int Y_W             = 8;
    localparam int COLOUR_W        = 3;
    localparam int CNT_W           = 12;
    localparam int PTR_W           = $clog2(NUM_GU);

    function automatic logic [PTR_W-1:0] onehot_index(input logic [NUM_GU-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_GU; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sprite_draw_arbiter_rr_pick.sv
// Round-robin winner: first set request bit at or above rr_ptr, wrapping to 0.
module rr_pick
    import sprite_draw_arbiter_pkg::*;
(
    input  logic [NUM_GU-1:0] req,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_GU-1:0] winner
);

    logic [2*NUM_GU-1:0] doubled;
    logic [NUM_GU-1:0]   rotated;
    logic [NUM_GU-1:0]   lowest;
    logic [2*NUM_GU-1:0] restored;

    // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign doubled  = {req, req} >> rr_ptr;
    assign rotated  = doubled[NUM_GU-1:0];
    assign lowest   = rotated & (~rotated + NUM_GU'(1));
    assign restored = {lowest, lowest} << rr_ptr;
    assign winner   = restored[2*NUM_GU-1:NUM_GU];

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Grants the shared frame-buffer write port to one graphing unit at a time,
// round-robin, with a per-grant timeout that forces release.
module sprite_draw_arbiter
    import sprite_draw_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_GU-1:0]          req,
    input  logic [NUM_GU-1:0]          gu_done,
    input  logic [NUM_GU*X_W-1:0]      gu_x,
    input  logic [NUM_GU*Y_W-1:0]      gu_y,
    input  logic [NUM_GU*COLOUR_W-1:0] gu_colour,
    input  logic [NUM_GU-1:0]          gu_we,
    output logic [NUM_GU-1:0]          gu_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COLOUR_W-1:0]        vga_colour,
    output logic                       vga_we,
    output logic [NUM_GU-1:0]          grant,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, next_state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  wait_cnt;
    logic [NUM_GU-1:0] winner;
    logic [PTR_W-1:0]  grant_idx;
    logic              done_granted;
    logic              load_grant, release_grant, clear_cnt, timed_out;

    rr_pick u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner)
    );

    assign grant_idx    = onehot_index(grant);
    assign done_granted = |(gu_done & grant);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        next_state    = state;
        load_grant    = 1'b0;
        release_grant = 1'b0;
        clear_cnt     = 1'b0;
        timed_out     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    load_grant = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                clear_cnt  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority so a late-but-valid completion is not flagged.
                if (done_granted) begin
                    next_state = ST_RELEASE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timed_out  = 1'b1;
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                release_grant = 1'b1;
                next_state    = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant       <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (load_grant) grant <= winner;
            if (release_grant) begin
                grant  <= '0;
                rr_ptr <= grant_idx + PTR_W'(1);
            end
            if (clear_cnt)             wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (timed_out) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_we     = 1'b0;
        if (state == ST_WAIT) begin
            vga_x      = gu_x[int'(grant_idx)*X_W +: X_W];
            vga_y      = gu_y[int'(grant_idx)*Y_W +: Y_W];
            vga_colour = gu_colour[int'(grant_idx)*COLOUR_W +: COLOUR_W];
            vga_we     = gu_we[grant_idx];
        end
    end

    assign gu_plot = (state == ST_ISSUE) ? grant : '0;
    assign busy    = (state != ST_IDLE);

endmodule

// File: doc/sprite_draw_arbiter.md
SPRITE_DRAW_ARBITER -- requirements
Module: sprite_draw_arbiter

Interface
REQ-001 Parameter: NUM_GU, 4, number of graphing-unit requesters; fixed at 4 for this revision.
REQ-002 Parameter: TIMEOUT, 4096, maximum WAIT cycles per grant before a forced release.
REQ-003 Port: clk  in  1  rising-edge system clock.
REQ-004 Port: resetn  in  1  reset; synchronous, active-low.
REQ-005 Port: req  in  4  level request per graphing unit (GU); bit i = GU i wants a draw pass.
REQ-006 Port: gu_done  in  4  one-cycle done pulse from each GU.
REQ-007 Port: gu_x  in  36  packed GU x outputs; GU i occupies bits [9i+8:9i].
REQ-008 Port: gu_y  in  32  packed GU y outputs; GU i occupies bits [8i+7:8i].
REQ-009 Port: gu_colour  in  12  packed GU colours; GU i occupies bits [3i+2:3i].
REQ-010 Port: gu_we  in  4  per-GU write enable.
REQ-011 Port: gu_plot  out  4  one-hot, one-cycle start pulse to the granted GU.
REQ-012 Port: vga_x  out  9; vga_y  out  8; vga_colour  out  3; vga_we  out  1: the shared frame-buffer write port.
REQ-013 Port: grant  out  4  one-hot current owner; 0 when no owner.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: timeout_err  out  1  sticky flag, set when any grant is force-released.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RELEASE; 2-bit encoding.
REQ-017 IDLE: if req != 0, latch the round-robin winner into grant and go to ISSUE; otherwise stay in IDLE with grant = 0.
REQ-018 Winner selection: the first set req bit scanning upward from rr_ptr, wrapping 3 -> 0.
REQ-019 ISSUE: lasts exactly one cycle; gu_plot = grant; clear the wait counter; go to WAIT.
REQ-020 WAIT: vga_x, vga_y, vga_colour and vga_we are a zero-latency combinational pass-through of the granted GU's fields.
REQ-021 Outside WAIT: vga_we = 0 and vga_x, vga_y, vga_colour = 0.
REQ-022 WAIT exit on done: go to RELEASE when gu_done[granted] = 1.
REQ-023 gu_done from non-granted GUs is ignored in all states.
REQ-024 Wait counter: 12-bit, increments every WAIT cycle.
REQ-025 Timeout: if the counter reaches TIMEOUT-1 without granted done, go to RELEASE and set timeout_err.
REQ-026 Done and timeout in the same cycle: done wins; timeout_err is not set.
REQ-027 RELEASE: lasts exactly one cycle; rr_ptr <= (granted index + 1) mod 4; grant <= 0; go to IDLE.
REQ-028 No preemption: deasserting req during ISSUE or WAIT does not end the grant.
REQ-029 Arbitration gap: a new grant is never issued sooner than one IDLE cycle after RELEASE.
REQ-030 gu_plot is 0 in every state except ISSUE.

Reset
REQ-031 On resetn = 0 at a clk edge: state <= IDLE, grant <= 0, rr_ptr <= 0, wait counter <= 0, timeout_err <= 0.
REQ-032 All outputs read 0 in the cycle after reset is applied.
REQ-033 Reset mid-WAIT aborts the grant immediately, with no done required and no RELEASE cycle.
REQ-034 timeout_err is cleared only by reset.

Structure
REQ-035 A shared package holds the state encoding, NUM_GU, the TIMEOUT default and the per-GU field widths (9/8/3).
REQ-036 One sub-module, rr_pick, computes the one-hot winner from req and rr_ptr combinationally.
REQ-037 The FSM, wait counter, rr_ptr register and output mux live in sprite_draw_arbiter.

Verification
REQ-038 Single requester, req=0001, GU0 done pulse 2050 cycles after plot:
  - gu_plot=0001 for exactly one cycle.
  - vga_we follows gu_we[0] for 2050 cycles.
  - grant returns to 0.
  - rr_ptr=1.
REQ-039 All four requesting continuously (req=1111): grants occur in order 0,1,2,3,0; each grant is separated by RELEASE plus IDLE cycles.
REQ-040 GU2 never pulses done, TIMEOUT=16: release occurs after 16 WAIT cycles; timeout_err=1 and stays 1; the next grant goes to GU3 if requesting.
REQ-041 While GU1 is granted, GU0 pulses gu_done and GU0's gu_we=1: GU1 stays granted and vga_we reflects gu_we[1] only.
REQ-042 resetn=0 asserted mid-WAIT on GU3: the next cycle shows grant=0, busy=0, vga_we=0, timeout_err=0; with req=1000 the following grant goes to GU3 (rr_ptr=0, scanning 0..3).
REQ-043 Granted done and timeout occur in the same cycle: normal release with timeout_err=0.
